// File: rtl/alu_pkg.sv
// Shared definitions for the ALU driver: widths, MIPS opcode/funct encodings,
// ALU flag bit positions, FSM states and the instruction classifier.
package alu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned FLAG_W = 3;

  // ALU flag vector is {zero, less, overflow}
  localparam int unsigned FLAG_ZERO = 2;
  localparam int unsigned FLAG_LESS = 1;
  localparam int unsigned FLAG_OVF  = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_EXEC, ST_WB} state_t;

  // What the writeback stage does with an instruction
  typedef enum logic [2:0] {
    K_WR_RD, K_WR_RT, K_SLT_RD, K_SLT_RT, K_BEQ, K_BNE, K_ILLEGAL
  } op_kind_t;

  typedef struct packed {
    op_kind_t kind;
    logic     trap;   // overflow raises an exception (add, sub, addi)
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d.kind = K_ILLEGAL;
    d.trap = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB: begin
            d.kind = K_WR_RD;
            d.trap = 1'b1;
          end
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLL, FN_SLLV, FN_SRL, FN_SRLV, FN_SRA, FN_SRAV: d.kind = K_WR_RD;
          FN_SLT, FN_SLTU: d.kind = K_SLT_RD;
          default: d.kind = K_ILLEGAL;
        endcase
      end
      OP_ADDI: begin
        d.kind = K_WR_RT;
        d.trap = 1'b1;
      end
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: d.kind = K_WR_RT;
      OP_SLTI, OP_SLTIU: d.kind = K_SLT_RT;
      OP_BEQ: d.kind = K_BEQ;
      OP_BNE: d.kind = K_BNE;
      default: d.kind = K_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 32x32 register file: one write port, two combinational read ports and a
// combinational debug read port. Register 0 is never written, so reads as 0.
// Ports: clk/reset, we/waddr/wdata write port, ra_*/rb_* read ports,
// dbg_addr/dbg_data debug port.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [XLEN-1:0]   ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [XLEN-1:0]   rb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  logic [XLEN-1:0] mem [NREGS];

  // Storage with full clear on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign ra_data  = mem[ra_addr];
  assign rb_data  = mem[rb_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_driver.sv
// Sequences one MIPS instruction at a time through an external combinational
// ALU: IDLE accepts, READ fetches operands, EXEC captures the ALU response,
// WB writes back and pulses done.
// Ports: clk/reset; in_valid/in_ready/in_instr instruction handshake;
// alu_instruction/alu_regA/alu_regB drive the ALU, alu_result/alu_flags
// return from it; done + done_taken/done_ovf/done_illegal report completion;
// dbg_addr/dbg_data read the register file.
module alu_driver
  import alu_pkg::*;
#(
  parameter bit DBG_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_instr,
  output logic [XLEN-1:0]   alu_instruction,
  output logic [XLEN-1:0]   alu_regA,
  output logic [XLEN-1:0]   alu_regB,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              done,
  output logic              done_taken,
  output logic              done_ovf,
  output logic              done_illegal,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  state_t          state;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] res_q;
  logic            less_q;
  logic            ovf_q;

  logic [XLEN-1:0]   rd_a;
  logic [XLEN-1:0]   rd_b;
  logic [XLEN-1:0]   rf_dbg;
  dec_t              dec_c;
  logic              we_c;
  logic [REG_AW-1:0] waddr_c;
  logic [XLEN-1:0]   wdata_c;

  assign dec_c = decode(instr_q[31:26], instr_q[5:0]);

  alu_regfile u_rf (
    .clk      (clk),
    .reset    (reset),
    .we       (we_c),
    .waddr    (waddr_c),
    .wdata    (wdata_c),
    .ra_addr  (instr_q[25:21]),
    .ra_data  (rd_a),
    .rb_addr  (instr_q[20:16]),
    .rb_data  (rd_b),
    .dbg_addr (dbg_addr),
    .dbg_data (rf_dbg)
  );

  assign dbg_data = DBG_EN ? rf_dbg : '0;

  // Writeback select; a trapping overflow suppresses the write
  always_comb begin
    we_c    = 1'b0;
    waddr_c = instr_q[15:11];
    wdata_c = res_q;
    if (state == ST_WB) begin
      case (dec_c.kind)
        K_WR_RD: we_c = !(dec_c.trap && ovf_q);
        K_WR_RT: begin
          waddr_c = instr_q[20:16];
          we_c    = !(dec_c.trap && ovf_q);
        end
        K_SLT_RD: begin
          wdata_c = {(XLEN-1)'(0), less_q};
          we_c    = 1'b1;
        end
        K_SLT_RT: begin
          waddr_c = instr_q[20:16];
          wdata_c = {(XLEN-1)'(0), less_q};
          we_c    = 1'b1;
        end
        default: we_c = 1'b0;
      endcase
    end
  end

  // Control FSM; done_* are loaded together with done so they are valid
  // exactly during the WB cycle and cleared otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      in_ready        <= 1'b1;
      instr_q         <= '0;
      alu_instruction <= '0;
      alu_regA        <= '0;
      alu_regB        <= '0;
      res_q           <= '0;
      less_q          <= 1'b0;
      ovf_q           <= 1'b0;
      done            <= 1'b0;
      done_taken      <= 1'b0;
      done_ovf        <= 1'b0;
      done_illegal    <= 1'b0;
    end else begin
      done         <= 1'b0;
      done_taken   <= 1'b0;
      done_ovf     <= 1'b0;
      done_illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            instr_q  <= in_instr;
            in_ready <= 1'b0;
            state    <= ST_READ;
          end
        end
        ST_READ: begin
          alu_regA        <= rd_a;
          alu_regB        <= rd_b;
          // ALU addresses its operands as registers 0 (A) and 1 (B)
          alu_instruction <= {instr_q[31:26], 5'd0, 5'd1, instr_q[15:0]};
          state           <= ST_EXEC;
        end
        ST_EXEC: begin
          res_q        <= alu_result;
          less_q       <= alu_flags[FLAG_LESS];
          ovf_q        <= alu_flags[FLAG_OVF];
          done         <= 1'b1;
          done_ovf     <= dec_c.trap && alu_flags[FLAG_OVF];
          done_illegal <= (dec_c.kind == K_ILLEGAL);
          done_taken   <= ((dec_c.kind == K_BEQ) &&  alu_flags[FLAG_ZERO]) ||
                          ((dec_c.kind == K_BNE) && !alu_flags[FLAG_ZERO]);
          state        <= ST_WB;
        end
        ST_WB: begin
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter: DBG_EN, 1, enables the debug read port (0 ties dbg_data to 0).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  instruction offered.
REQ-005 SHALL have port: in_ready  output  1  driver can accept an instruction.
REQ-006 SHALL have port: in_instr  input  32  MIPS instruction word.
REQ-007 SHALL have port: alu_instruction  output  32  instruction to ALU, rs/rt fields rewritten.
REQ-008 SHALL have port: alu_regA  output  32  operand for ALU register address 0.
REQ-009 SHALL have port: alu_regB  output  32  operand for ALU register address 1.
REQ-010 SHALL have port: alu_result  input  32  combinational ALU result.
REQ-011 SHALL have port: alu_flags  input  3  ALU flags {zero, less, overflow}.
REQ-012 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port: done_taken  output  1  branch taken, valid with done.
REQ-014 SHALL have port: done_ovf  output  1  overflow exception, valid with done.
REQ-015 SHALL have port: done_illegal  output  1  unsupported opcode/funct, valid with done.
REQ-016 SHALL have port: dbg_addr  input  5  register-file debug read address.
REQ-017 SHALL have port: dbg_data  output  32  combinational RF[dbg_addr].

Function
REQ-018 SHALL own a 32x32 register file; register 0 reads 0 and ignores writes.
REQ-019 SHALL use FSM IDLE -> READ -> EXEC -> WB -> IDLE, one cycle per state; in_ready=1 only in IDLE.
REQ-020 SHALL latch in_instr on in_valid&&in_ready; in_valid outside IDLE is ignored (no queueing).
REQ-021 SHALL in READ register alu_regA=RF[rs], alu_regB=RF[rt], alu_instruction=in_instr with [25:21]=00000, [20:16]=00001.
REQ-022 SHALL in EXEC capture alu_result and alu_flags into internal registers.
REQ-023 SHALL in WB write back and pulse done; accept-to-done latency exactly 3 cycles; next accept no earlier than the cycle after done.
REQ-024 SHALL write RF[rd] for R-type add, addu, sub, subu, and, or, xor, nor, sll, sllv, srl, srlv, sra, srav.
REQ-025 SHALL write RF[rt] for addi, addiu, andi, ori, xori.
REQ-026 SHALL write 32'd1/32'd0 from captured flags[1] to rd (slt, sltu) or rt (slti, sltiu).
REQ-027 SHALL set done_ovf and suppress writeback when flags[0]=1 for add, addi or sub only; addu/addiu/subu never trap.
REQ-028 SHALL set done_taken = flags[2] for beq, = !flags[2] for bne; no writeback for branches.
REQ-029 SHALL treat lw, sw and all other encodings as illegal: done_illegal=1, no writeback.
REQ-030 SHALL hold done_taken/done_ovf/done_illegal at 0 whenever done=0.
REQ-031 SHALL make a WB write visible on dbg_data in the cycle after done.

Reset
REQ-032 SHALL on reset asynchronously enter IDLE, clear all RF entries to 0, and drive in_ready=1, done=0, all done_* flags=0, alu_instruction=alu_regA=alu_regB=0.
REQ-033 SHALL on reset mid-instruction (READ/EXEC/WB) abandon it: no writeback, no done pulse.

Structure
REQ-034 SHALL place opcode/funct constants, flag bit indices and the FSM state enum in shared package alu_pkg.
REQ-035 SHALL implement the register file as sub-module alu_regfile (one write port, two read ports plus debug port).

Verification
REQ-036 SHALL cover: RF[1]=7fffffff, RF[2]=1, add r3,r1,r2 -> done with done_ovf=1, RF[3] unchanged at 0.
REQ-037 SHALL cover: RF[1]=-2, RF[2]=3, addu r3,r1,r2 -> RF[3]=1; alu_instruction rs=0, rt=1 in EXEC.
REQ-038 SHALL cover: RF[4]=-6, RF[5]=-6, beq r4,r5 -> done_taken=1; bne same -> done_taken=0.
REQ-039 SHALL cover: RF[1]=-1, sltu r6,r1,r0 -> RF[6]=0; slt r6,r1,r0 -> RF[6]=1.
REQ-040 SHALL cover: in_valid held high continuously -> accept every 4th cycle, done 3 cycles after each accept.
REQ-041 SHALL cover: reset asserted during EXEC of ori r7,r0,0xff00 -> no done, RF[7]=0, in_ready=1 after reset release.
